// File: rtl/exp6_pkg.sv
// Shared state codes for the exp6 game controller.
// The datapath and the top-level debug decoders use the same codes.
package exp6_pkg;

  localparam int ESTADO_W = 4;

  // All 16 codes are used, so the state register has no illegal values.
  typedef enum logic [ESTADO_W-1:0] {
    st_inicial          = 4'd0,
    st_preparacao       = 4'd1,
    st_inicio_rodada    = 4'd2,
    st_mostra           = 4'd3,
    st_apaga            = 4'd4,
    st_espera_jogada    = 4'd5,
    st_registra         = 4'd6,
    st_compara          = 4'd7,
    st_proximo          = 4'd8,
    st_ultima           = 4'd9,
    st_espera_escrita   = 4'd10,
    st_registra_escrita = 4'd11,
    st_escreve          = 4'd12,
    st_fim_acertou      = 4'd13,
    st_fim_errou        = 4'd14,
    st_fim_timeout      = 4'd15
  } estado_t;

endpackage

// File: rtl/exp6_unidade_controle.sv
// Moore control FSM for the exp6 memory game: sequences the round and
// address counters, the play register, the LED-mode register, the RAM
// write and the end-of-game flags. Outputs depend on the current state
// only; db_estado exposes the state code for debug and checkers.
//
// Handshake: there is no valid/ready pair. jogada_feita is a one-cycle
// pulse from the button detector and is only acted on in the two
// play-wait states; every other input is a level sampled on the clock.
module exp6_unidade_controle
  import exp6_pkg::*;
#(
  parameter logic TIMEOUT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       fimL,
  input  logic       timeout,
  output logic       zeraCR,
  output logic       zeraE,
  output logic       contaCR,
  output logic       contaE,
  output logic       limpaRC,
  output logic       registraRC,
  output logic       zeraLeds,
  output logic       registraLeds,
  output logic       led_selector,
  output logic       contaT,
  output logic       ram_enable,
  output logic       mux_leds,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t estado_prox;

  // State register; reset aborts any game and returns to inicial.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= st_inicial;
    end else begin
      estado <= estado_prox;
    end
  end

  // Next-state logic. In the play-wait states a play beats a timeout
  // arriving in the same cycle; the timeout there is gated by TIMEOUT_EN,
  // while the display timeout in mostra is always honoured.
  always_comb begin
    estado_prox = estado;
    case (estado)
      st_inicial:          if (iniciar) estado_prox = st_preparacao;
      st_preparacao:       estado_prox = st_inicio_rodada;
      st_inicio_rodada:    estado_prox = st_mostra;
      st_mostra:           if (timeout) estado_prox = st_apaga;
      st_apaga:            estado_prox = st_espera_jogada;
      st_espera_jogada: begin
        if (jogada_feita)                 estado_prox = st_registra;
        else if (timeout && TIMEOUT_EN)   estado_prox = st_fim_timeout;
      end
      st_registra:         estado_prox = st_compara;
      st_compara: begin
        if (!jogada_correta)              estado_prox = st_fim_errou;
        else if (enderecoIgualRodada)     estado_prox = st_ultima;
        else                              estado_prox = st_proximo;
      end
      st_proximo:          estado_prox = st_espera_jogada;
      st_ultima:           estado_prox = fimL ? st_fim_acertou : st_espera_escrita;
      st_espera_escrita: begin
        if (jogada_feita)                 estado_prox = st_registra_escrita;
        else if (timeout && TIMEOUT_EN)   estado_prox = st_fim_timeout;
      end
      st_registra_escrita: estado_prox = st_escreve;
      st_escreve:          estado_prox = st_inicio_rodada;
      st_fim_acertou,
      st_fim_errou,
      st_fim_timeout:      if (iniciar) estado_prox = st_preparacao;
      default:             estado_prox = st_inicial;
    endcase
  end

  // Output decode from the current state; everything defaults to 0.
  always_comb begin
    zeraCR       = 1'b0;
    zeraE        = 1'b0;
    contaCR      = 1'b0;
    contaE       = 1'b0;
    limpaRC      = 1'b0;
    registraRC   = 1'b0;
    zeraLeds     = 1'b0;
    registraLeds = 1'b0;
    led_selector = 1'b0;
    contaT       = 1'b0;
    ram_enable   = 1'b0;
    mux_leds     = 1'b0;
    pronto       = 1'b0;
    ganhou       = 1'b0;
    perdeu       = 1'b0;
    case (estado)
      st_preparacao: begin
        zeraCR   = 1'b1;
        zeraE    = 1'b1;
        limpaRC  = 1'b1;
        zeraLeds = 1'b1;
      end
      st_inicio_rodada: begin
        zeraE        = 1'b1;
        registraLeds = 1'b1;
        led_selector = 1'b1;
      end
      st_mostra: begin
        contaT       = 1'b1;
        mux_leds     = 1'b1;
        led_selector = 1'b1;
      end
      st_apaga: begin
        limpaRC      = 1'b1;
        registraLeds = 1'b1;
      end
      st_espera_jogada,
      st_espera_escrita:   contaT = 1'b1;
      st_registra,
      st_registra_escrita: registraRC = 1'b1;
      st_proximo:          contaE = 1'b1;
      st_escreve: begin
        ram_enable = 1'b1;
        contaCR    = 1'b1;
      end
      st_fim_acertou: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      st_fim_errou,
      st_fim_timeout: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// Directed bench for exp6_unidade_controle. Two instances share the
// inputs: dut uses TIMEOUT_EN=1, dut_nt uses TIMEOUT_EN=0.
module tb_exp6_unidade_controle;

  // Output vector bit positions (bench-side packing).
  localparam int B_ZCR = 14, B_ZE = 13, B_CCR = 12, B_CE = 11, B_LRC = 10;
  localparam int B_RRC = 9, B_ZL = 8, B_RL = 7, B_LS = 6, B_CT = 5;
  localparam int B_RAM = 4, B_MUX = 3, B_PR = 2, B_GA = 1, B_PE = 0;

  logic clock = 1'b0;
  logic reset, iniciar, jogada_feita, jogada_correta;
  logic enderecoIgualRodada, fimL, timeout;

  logic zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC, zeraLeds;
  logic registraLeds, led_selector, contaT, ram_enable, mux_leds;
  logic pronto, ganhou, perdeu;
  logic [3:0] db_estado;

  logic n_zeraCR, n_zeraE, n_contaCR, n_contaE, n_limpaRC, n_registraRC;
  logic n_zeraLeds, n_registraLeds, n_led_selector, n_contaT, n_ram_enable;
  logic n_mux_leds, n_pronto, n_ganhou, n_perdeu;
  logic [3:0] n_db_estado;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock generation.
  always #5 clock = ~clock;

  exp6_unidade_controle #(.TIMEOUT_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
    .enderecoIgualRodada(enderecoIgualRodada), .fimL(fimL), .timeout(timeout),
    .zeraCR(zeraCR), .zeraE(zeraE), .contaCR(contaCR), .contaE(contaE),
    .limpaRC(limpaRC), .registraRC(registraRC), .zeraLeds(zeraLeds),
    .registraLeds(registraLeds), .led_selector(led_selector), .contaT(contaT),
    .ram_enable(ram_enable), .mux_leds(mux_leds), .pronto(pronto),
    .ganhou(ganhou), .perdeu(perdeu), .db_estado(db_estado)
  );

  exp6_unidade_controle #(.TIMEOUT_EN(1'b0)) dut_nt (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
    .enderecoIgualRodada(enderecoIgualRodada), .fimL(fimL), .timeout(timeout),
    .zeraCR(n_zeraCR), .zeraE(n_zeraE), .contaCR(n_contaCR), .contaE(n_contaE),
    .limpaRC(n_limpaRC), .registraRC(n_registraRC), .zeraLeds(n_zeraLeds),
    .registraLeds(n_registraLeds), .led_selector(n_led_selector),
    .contaT(n_contaT), .ram_enable(n_ram_enable), .mux_leds(n_mux_leds),
    .pronto(n_pronto), .ganhou(n_ganhou), .perdeu(n_perdeu),
    .db_estado(n_db_estado)
  );

  wire [14:0] outs = {zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC,
                      zeraLeds, registraLeds, led_selector, contaT,
                      ram_enable, mux_leds, pronto, ganhou, perdeu};
  wire [14:0] n_outs = {n_zeraCR, n_zeraE, n_contaCR, n_contaE, n_limpaRC,
                        n_registraRC, n_zeraLeds, n_registraLeds,
                        n_led_selector, n_contaT, n_ram_enable, n_mux_leds,
                        n_pronto, n_ganhou, n_perdeu};

  // Expected output vector for each state, written from the state table.
  function automatic logic [14:0] exp_outs(input int s);
    logic [14:0] v;
    v = '0;
    case (s)
      1:  begin v[B_ZCR] = 1; v[B_ZE] = 1; v[B_LRC] = 1; v[B_ZL] = 1; end
      2:  begin v[B_ZE] = 1; v[B_RL] = 1; v[B_LS] = 1; end
      3:  begin v[B_CT] = 1; v[B_MUX] = 1; v[B_LS] = 1; end
      4:  begin v[B_LRC] = 1; v[B_RL] = 1; end
      5, 10: v[B_CT] = 1;
      6, 11: v[B_RRC] = 1;
      8:  v[B_CE] = 1;
      12: begin v[B_RAM] = 1; v[B_CCR] = 1; end
      13: begin v[B_PR] = 1; v[B_GA] = 1; end
      14, 15: begin v[B_PR] = 1; v[B_PE] = 1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Step, then check state and outputs of the main instance.
  task automatic go(input string tag, input int s);
    step();
    check_eq({tag, "_state"}, 32'(db_estado), 32'(s));
    check_eq({tag, "_outs"}, 32'(outs), 32'(exp_outs(s)));
  endtask

  task automatic go_both(input string tag, input int s);
    go(tag, s);
    check_eq({tag, "_nt_state"}, 32'(n_db_estado), 32'(s));
  endtask

  // From inicial/end states: iniciar -> 1,2,3, timeout -> 4,5.
  task automatic start_round(input string tag);
    iniciar = 1; go_both({tag, "_prep"}, 1);
    iniciar = 0; go_both({tag, "_ini"}, 2);
    go_both({tag, "_mostra"}, 3);
    iniciar = 1; go_both({tag, "_mostra_hold"}, 3);
    iniciar = 0; timeout = 1; go_both({tag, "_apaga"}, 4);
    timeout = 0; go_both({tag, "_espera"}, 5);
  endtask

  // Stimulus sequence.
  initial begin
    reset = 1; iniciar = 0; jogada_feita = 0; jogada_correta = 1;
    enderecoIgualRodada = 0; fimL = 0; timeout = 0;
    #2;
    iniciar = 1;
    go_both("reset_a", 0);
    go_both("reset_b", 0);
    reset = 0; iniciar = 0;
    go_both("idle", 0);

    // Show / erase and one correct play that is not the last in the round.
    start_round("r1");
    jogada_feita = 1; go_both("r1_reg", 6);
    jogada_feita = 0; go_both("r1_cmp", 7);
    go_both("r1_prox", 8);
    go_both("r1_back", 5);

    // Play and timeout together: play wins; then a wrong play.
    jogada_feita = 1; timeout = 1; go_both("both_reg", 6);
    jogada_feita = 0; timeout = 0; jogada_correta = 0;
    go_both("err_cmp", 7);
    iniciar = 1; go_both("err_fim", 14);
    iniciar = 0; go_both("err_hold", 14);
    jogada_correta = 1;

    // Timeout alone in espera_jogada: 15 vs. stays in 5 without TIMEOUT_EN.
    start_round("r2");
    timeout = 1; step();
    check_eq("to_state", 32'(db_estado), 32'd15);
    check_eq("to_outs", 32'(outs), 32'(exp_outs(15)));
    check_eq("to_nt_state", 32'(n_db_estado), 32'd5);
    check_eq("to_nt_outs", 32'(n_outs), 32'(exp_outs(5)));
    timeout = 0;

    // Two reset cycles while dut_nt sits in espera_jogada.
    reset = 1; iniciar = 1; step(); step();
    check_eq("rst5_nt_state", 32'(n_db_estado), 32'd0);
    check_eq("rst5_nt_outs", 32'(n_outs), 32'd0);
    check_eq("rst5_state", 32'(db_estado), 32'd0);
    check_eq("rst5_outs", 32'(outs), 32'd0);
    reset = 0; iniciar = 0;

    // Last play of the last round: win.
    start_round("r3");
    enderecoIgualRodada = 1; fimL = 1;
    jogada_feita = 1; go_both("win_reg", 6);
    jogada_feita = 0; go_both("win_cmp", 7);
    go_both("win_ult", 9);
    go_both("win_fim", 13);
    go_both("win_hold", 13);

    // Last play of a non-final round: wait for the new play and write it.
    start_round("r4");
    fimL = 0;
    jogada_feita = 1; go_both("wr_reg", 6);
    jogada_feita = 0; go_both("wr_cmp", 7);
    go_both("wr_ult", 9);
    go_both("wr_esp", 10);
    go_both("wr_esp_hold", 10);
    jogada_feita = 1; go_both("wr_regesc", 11);
    jogada_feita = 0; go_both("wr_escreve", 12);
    go_both("wr_nextround", 2);
    go_both("wr_mostra", 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the sequence above never completes.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
